alu_issue_stage: RTL and testbench

- Pipeline register stage directly upstream of the ALU.
- Captures decoded operands and control from decode/register-read and selects register or immediate for operand B.
- Resolves RAW hazards by forwarding from the ALU result (EX) and from writeback (WB).
- Presents stable A, B and Op to the ALU under a valid/ready handshake, with stall and flush support.

---
 rtl/alu_issue_stage_pkg.sv | 35 +++
 rtl/alu_issue_stage_fwd_select.sv | 45 ++++
 rtl/alu_issue_stage.sv | 147 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_pkg
// Shared definitions for the ALU issue stage:
//   - default datapath / register-index widths
//   - ALU op-code constants
//   - stage occupancy state type (EMPTY / FULL)
//   - is_legal_alu_op(): true for the op codes the ALU implements
// ---------------------------------------------------------------------------
package alu_issue_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  function automatic logic is_legal_alu_op(input logic [3:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_select.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_fwd_select
// Combinational operand forwarding mux for one source register.
// Priority: x0 -> zero, then EX result, then WB data, then register file.
// Ports:
//   addr      in  REG_AW  source register index
//   reg_data  in  XLEN    register-file read data
//   ex_en     in  1       EX candidate is a valid, retiring register write
//   ex_rd     in  REG_AW  EX destination index
//   ex_data   in  XLEN    EX (ALU) result
//   wb_en     in  1       writeback write enable
//   wb_rd     in  REG_AW  writeback destination index
//   wb_data   in  XLEN    writeback data
//   fwd_data  out XLEN    selected operand value
// ---------------------------------------------------------------------------
module alu_issue_stage_fwd_select
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic              ex_en,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    // x0 check comes first so a write to x0 in EX or WB never leaks through.
    if (addr == '0) begin
      fwd_data = '0;
    end else if (ex_en && (ex_rd == addr)) begin
      fwd_data = ex_data;
    end else if (wb_en && (wb_rd == addr)) begin
      fwd_data = wb_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Single pipeline register directly upstream of the ALU. Captures decoded
// operands/control under a valid/ready handshake, resolves RAW hazards by
// forwarding from EX (the instruction currently held here, as it leaves)
// and from WB, and selects register or immediate for operand B.
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic              use_imm,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic [3:0]        op_in,
  input  logic              flush,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              op_illegal
);

  stage_state_t      state_p1;
  stage_state_t      state_nxt;
  logic              vld_p1;
  logic              capture_p0;
  logic              ex_en_p0;
  logic [XLEN-1:0]   fwd_a_p0;
  logic [XLEN-1:0]   fwd_b_p0;
  logic [XLEN-1:0]   opb_p0;
  logic [XLEN-1:0]   alu_a_p1;
  logic [XLEN-1:0]   alu_b_p1;
  logic [3:0]        alu_op_p1;
  logic [REG_AW-1:0] rd_p1;
  logic              rw_p1;
  logic              ill_p1;

  // ---- p0: handshake, forwarding and operand selection (combinational) ----
  assign vld_p1     = (state_p1 == ST_FULL);
  assign in_ready   = !flush && (!vld_p1 || out_ready);
  assign capture_p0 = in_valid && in_ready;

  // The held instruction's result only counts as forwardable on the cycle it
  // actually leaves for the ALU; a stalled or empty stage offers nothing.
  assign ex_en_p0 = vld_p1 && out_ready && rw_p1;

  alu_issue_stage_fwd_select #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .addr     (rs1_addr),
    .reg_data (rs1_data),
    .ex_en    (ex_en_p0),
    .ex_rd    (rd_p1),
    .ex_data  (ex_result),
    .wb_en    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fwd_data (fwd_a_p0)
  );

  alu_issue_stage_fwd_select #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .addr     (rs2_addr),
    .reg_data (rs2_data),
    .ex_en    (ex_en_p0),
    .ex_rd    (rd_p1),
    .ex_data  (ex_result),
    .wb_en    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fwd_data (fwd_b_p0)
  );

  // The immediate bypasses forwarding entirely.
  assign opb_p0 = use_imm ? imm : fwd_b_p0;

  // ---- p0 -> p1: occupancy state ----
  always_comb begin
    state_nxt = state_p1;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else if (capture_p0) begin
      state_nxt = ST_FULL;
    end else if (out_ready) begin
      state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= ST_EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // ---- p0 -> p1: operand / control register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_p1  <= '0;
      alu_b_p1  <= '0;
      alu_op_p1 <= ALU_ADD;
      rd_p1     <= '0;
      rw_p1     <= 1'b0;
      ill_p1    <= 1'b0;
    end else if (capture_p0) begin
      alu_a_p1  <= fwd_a_p0;
      alu_b_p1  <= opb_p0;
      alu_op_p1 <= op_in;
      rd_p1     <= rd_addr;
      rw_p1     <= reg_write;
      ill_p1    <= !is_legal_alu_op(op_in);
    end
  end

  // ---- p1: registered outputs ----
  assign out_valid     = vld_p1;
  assign alu_a         = alu_a_p1;
  assign alu_b         = alu_b_p1;
  assign alu_op        = alu_op_p1;
  assign out_rd        = rd_p1;
  assign out_reg_write = rw_p1;
  assign op_illegal    = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0, wb_rd = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0, ex_result = '0, wb_data = '0;
  logic        use_imm = 1'b0, reg_write = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [3:0]  op_in = 4'b0010;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write, op_illegal;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .use_imm(use_imm), .rd_addr(rd_addr), .reg_write(reg_write),
    .op_in(op_in), .flush(flush), .ex_result(ex_result), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .op_illegal(op_illegal)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the instruction the stage should be holding.
  logic        m_valid;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_rw, m_ill;

  // Bit k set when op code k is implemented by the ALU.
  logic [15:0] legal_mask = 16'b0001_0000_1100_0111;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [4:0] addr, input logic [31:0] data);
    if (addr == 5'd0) return 32'd0;
    if (m_valid && out_ready && m_rw && m_rd == addr) return ex_result;
    if (wb_we && wb_rd == addr) return wb_data;
    return data;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_op = 4'b0010; m_rd = '0; m_rw = 1'b0; m_ill = 1'b0;
  endtask

  // Drives ex_result from the model's held instruction, advances one clock
  // and updates the model; returns 1ns after the rising edge.
  task automatic tick();
    logic        cap, nv;
    logic [31:0] na, nb;
    ex_result = alu_ref(m_op, m_a, m_b);
    cap = in_valid && !flush && (!m_valid || out_ready);
    na  = fwd_ref(rs1_addr, rs1_data);
    nb  = use_imm ? imm : fwd_ref(rs2_addr, rs2_data);
    nv  = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : m_valid;
    @(posedge clk);
    m_valid = nv;
    if (cap) begin
      m_a = na; m_b = nb; m_op = op_in; m_rd = rd_addr; m_rw = reg_write;
      m_ill = !legal_mask[op_in];
    end
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] r1, input logic [31:0] d1,
                           input logic [4:0] r2, input logic [31:0] d2, input logic ui,
                           input logic [31:0] im, input logic [4:0] rd, input logic rw,
                           input logic [3:0] op);
    in_valid = v; rs1_addr = r1; rs1_data = d1; rs2_addr = r2; rs2_data = d2;
    use_imm = ui; imm = im; rd_addr = rd; reg_write = rw; op_in = op;
  endtask

  task automatic test_basic();
    wb_we = 1'b0; out_ready = 1'b1; flush = 1'b0;
    set_instr(1'b1, 5'd1, 32'd1, 5'd2, 32'd5, 1'b0, 32'd0, 5'd6, 1'b1, 4'b0000);
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_cmp++; if (alu_a !== 32'd1) begin n_err++; $display("FAIL basic_a: got %h want 1", alu_a); end
    n_cmp++; if (alu_b !== 32'd5) begin n_err++; $display("FAIL basic_b: got %h want 5", alu_b); end
    n_cmp++; if (alu_op !== 4'b0000) begin n_err++; $display("FAIL basic_op: got %b want 0000", alu_op); end
    n_cmp++; if (op_illegal !== 1'b0) begin n_err++; $display("FAIL basic_ill: got %b want 0", op_illegal); end
    n_cmp++; if (out_rd !== 5'd6 || out_reg_write !== 1'b1) begin n_err++; $display("FAIL basic_rd: got %0d/%b want 6/1", out_rd, out_reg_write); end
  endtask

  task automatic test_reset();
    // Stage is FULL here; drop reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (alu_op !== 4'b0010) begin n_err++; $display("FAIL rst_op: got %b want 0010", alu_op); end
    n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_err++; $display("FAIL rst_ab: got %h/%h want 0/0", alu_a, alu_b); end
    n_cmp++; if (out_rd !== 5'd0 || out_reg_write !== 1'b0 || op_illegal !== 1'b0) begin
      n_err++; $display("FAIL rst_ctl: got rd=%0d rw=%b ill=%b want 0/0/0", out_rd, out_reg_write, op_illegal); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    wb_we = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_valid = 1'b0; tick();
    set_instr(1'b1, 5'd1, 32'd7, 5'd2, 32'd2, 1'b0, 32'd0, 5'd3, 1'b1, 4'b0110);
    tick();
    n_cmp++; if (alu_a !== 32'd7 || alu_b !== 32'd2) begin n_err++; $display("FAIL ex_i1: got %h/%h want 7/2", alu_a, alu_b); end
    set_instr(1'b1, 5'd3, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd8, 1'b0, 4'b0010);
    tick();
    n_cmp++; if (alu_a !== 32'd5) begin n_err++; $display("FAIL ex_fwd: got %h want 5", alu_a); end
    // WB-only hit
    in_valid = 1'b0; tick();
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD;
    set_instr(1'b1, 5'd4, 32'd0, 5'd5, 32'h10, 1'b0, 32'd0, 5'd4, 1'b1, 4'b0010);
    tick();
    n_cmp++; if (alu_a !== 32'hDEAD) begin n_err++; $display("FAIL wb_fwd: got %h want dead", alu_a); end
    n_cmp++; if (alu_b !== 32'h10) begin n_err++; $display("FAIL wb_nohit_b: got %h want 10", alu_b); end
    // EX (0xDEAD+0x10) and WB (0xDEAD) both hit r4: EX wins
    set_instr(1'b1, 5'd4, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd9, 1'b0, 4'b0010);
    tick();
    n_cmp++; if (alu_a !== 32'hDEBD) begin n_err++; $display("FAIL ex_over_wb: got %h want debd", alu_a); end
    wb_we = 1'b0;
  endtask

  task automatic test_x0_imm();
    out_ready = 1'b1; wb_we = 1'b0;
    set_instr(1'b1, 5'd6, 32'd1, 5'd7, 32'd1, 1'b0, 32'd0, 5'd2, 1'b1, 4'b0010);
    tick();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd9;
    set_instr(1'b1, 5'd0, 32'h55, 5'd2, 32'h77, 1'b1, 32'hFFFF_FFFF, 5'd1, 1'b0, 4'b0001);
    tick();
    n_cmp++; if (alu_a !== 32'd0) begin n_err++; $display("FAIL x0_a: got %h want 0", alu_a); end
    n_cmp++; if (alu_b !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL imm_b: got %h want ffffffff", alu_b); end
    wb_we = 1'b0;
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    set_instr(1'b1, 5'd9, 32'h1111, 5'd10, 32'h2222, 1'b0, 32'd0, 5'd11, 1'b1, 4'b0001);
    tick();
    out_ready = 1'b0;
    set_instr(1'b1, 5'd12, 32'h3333, 5'd13, 32'h4444, 1'b0, 32'd0, 5'd14, 1'b1, 4'b0000);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || alu_a !== 32'h1111 || alu_b !== 32'h2222 || alu_op !== 4'b0001 || out_rd !== 5'd11) begin
        n_err++; $display("FAIL stall_hold%0d: got v=%b a=%h b=%h op=%b rd=%0d want 1/1111/2222/0001/11",
                          i, out_valid, alu_a, alu_b, alu_op, out_rd);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL unstall_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (alu_a !== 32'h3333 || alu_b !== 32'h4444 || alu_op !== 4'b0000 || out_rd !== 5'd14) begin
      n_err++; $display("FAIL unstall_cap: got a=%h b=%h op=%b rd=%0d want 3333/4444/0000/14", alu_a, alu_b, alu_op, out_rd); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    set_instr(1'b1, 5'd15, 32'h5555, 5'd16, 32'h6666, 1'b0, 32'd0, 5'd17, 1'b1, 4'b0010);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_cmp++; if (alu_a !== 32'h3333) begin n_err++; $display("FAIL flush_nocap: got %h want 3333", alu_a); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    for (int op = 0; op < 16; op++) begin
      set_instr(1'b1, 5'd1, 32'd3, 5'd2, 32'd4, 1'b0, 32'd0, 5'd5, 1'b1, 4'(op));
      tick();
      n_cmp++;
      if (op_illegal !== !legal_mask[op] || alu_op !== 4'(op)) begin
        n_err++; $display("FAIL illegal_op%0d: got ill=%b op=%b want ill=%b op=%b", op, op_illegal, alu_op, !legal_mask[op], 4'(op));
      end
    end
    set_instr(1'b1, 5'd1, 32'd3, 5'd2, 32'd4, 1'b0, 32'd0, 5'd5, 1'b1, 4'b0011);
    tick();
    n_cmp++; if (op_illegal !== 1'b1 || alu_op !== 4'b0011) begin
      n_err++; $display("FAIL illegal_0011: got ill=%b op=%b want 1/0011", op_illegal, alu_op); end
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int i = 0; i < 300; i++) begin
      set_instr(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)), $urandom,
                5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      wb_we     = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 3));
      wb_data   = $urandom;
      #1;
      exp_ready = !flush && (!m_valid || out_ready);
      n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, exp_ready); end
      tick();
      n_cmp++;
      if (out_valid !== m_valid || alu_a !== m_a || alu_b !== m_b || alu_op !== m_op ||
          out_rd !== m_rd || out_reg_write !== m_rw || op_illegal !== m_ill) begin
        n_err++;
        $display("FAIL rnd_out[%0d]: got v=%b a=%h b=%h op=%h rd=%0d rw=%b ill=%b want v=%b a=%h b=%h op=%h rd=%0d rw=%b ill=%b",
                 i, out_valid, alu_a, alu_b, alu_op, out_rd, out_reg_write, op_illegal,
                 m_valid, m_a, m_b, m_op, m_rd, m_rw, m_ill);
      end
    end
    flush = 1'b0; in_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_reset();
    test_forward();
    test_x0_imm();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
